// File: rtl/alu_pkg.sv
// Opcode encodings and FSM state type shared by the multi-cycle ALU and the
// datapath control unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LSL   = 4'b0011;
    localparam logic [3:0] ALU_LSR   = 4'b0100;
    localparam logic [3:0] ALU_MUL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-and-add multiplier: exactly N iterations per start,
// no early exit, so latency does not depend on the operands.
module alu_shift_add_mul #(
    parameter int N  = 64,
    parameter int CW = $clog2(N + 1)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_last,
    output logic [N-1:0] o_product
);

    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_mcand;
    logic [N-1:0]  r_mplier;
    logic [CW-1:0] r_cnt;

    // Load on start, then one add/shift step per cycle until the counter drains.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_cnt    <= CW'(N);
        end else if (r_cnt != '0) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end else begin
                r_acc <= r_acc;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
        end else begin
            r_acc <= r_acc;
        end
    end

    // High during the final iteration so the caller can leave on the same edge.
    assign o_last    = (r_cnt == CW'(1));
    assign o_product = r_acc;

endmodule

// File: rtl/multicycle_alu.sv
// Clocked ALU with Start/Busy/Done handshake, registered NZCV flags and an
// iterative multiply; single-cycle ops finish one cycle after accept.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int N   = 64,
    parameter int SHW = $clog2(N),
    parameter int CW  = $clog2(N + 1)
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [3:0]   ALUCtrl,
    input  logic [N-1:0] BusA,
    input  logic [N-1:0] BusB,
    output logic [N-1:0] BusW,
    output logic         Zero,
    output logic         Negative,
    output logic         Carry,
    output logic         Overflow,
    output logic         Illegal,
    output logic         Busy,
    output logic         Done
);

    alu_state_t   r_state;
    logic [3:0]   r_op;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;

    logic         w_accept;
    logic         w_mul_start;
    logic         w_mul_last;
    logic [N-1:0] w_product;
    logic         w_sub;
    logic [N-1:0] w_b_eff;
    logic [N:0]   w_sum;
    logic         w_arith_ovf;
    logic [N-1:0] w_result;
    logic         w_carry;
    logic         w_ovf;

    assign w_accept    = (r_state == ST_IDLE) && Start;
    assign w_mul_start = w_accept && (ALUCtrl == ALU_MUL);

    alu_shift_add_mul #(
        .N  (N),
        .CW (CW)
    ) u_mul (
        .i_clk     (Clk),
        .i_reset   (Reset),
        .i_start   (w_mul_start),
        .i_a       (BusA),
        .i_b       (BusB),
        .o_last    (w_mul_last),
        .o_product (w_product)
    );

    // SUB reuses the adder as A + ~B + 1 so Carry means "no borrow".
    assign w_sub       = (r_op == ALU_SUB);
    assign w_b_eff     = w_sub ? ~r_b : r_b;
    assign w_sum       = {1'b0, r_a} + {1'b0, w_b_eff} + {{N{1'b0}}, w_sub};
    assign w_arith_ovf = (r_a[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != r_a[N-1]);

    // Result and carry/overflow selection from the latched opcode.
    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (r_op)
            ALU_AND:   w_result = r_a & r_b;
            ALU_OR:    w_result = r_a | r_b;
            ALU_LSL:   w_result = r_a << r_b[SHW-1:0];
            ALU_LSR:   w_result = r_a >> r_b[SHW-1:0];
            ALU_MUL:   w_result = w_product;
            ALU_PASSB: w_result = r_b;
            ALU_ADD, ALU_SUB: begin
                w_result = w_sum[N-1:0];
                w_carry  = w_sum[N];
                w_ovf    = w_arith_ovf;
            end
            default:   w_result = '0;
        endcase
    end

    // Control FSM; all visible outputs are registered and change only in DONE or reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_op     <= 4'b0000;
            r_a      <= '0;
            r_b      <= '0;
            BusW     <= '0;
            Zero     <= 1'b1;
            Negative <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            Illegal  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_op    <= ALUCtrl;
                        r_a     <= BusA;
                        r_b     <= BusB;
                        Busy    <= 1'b1;
                        r_state <= (ALUCtrl == ALU_MUL) ? ST_MUL : ST_DONE;
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                ST_MUL: begin
                    Busy <= 1'b1;
                    if (w_mul_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_MUL;
                    end
                end
                ST_DONE: begin
                    BusW     <= w_result;
                    Zero     <= (w_result == '0);
                    Negative <= w_result[N-1];
                    Carry    <= w_carry;
                    Overflow <= w_ovf;
                    Illegal  <= ~is_legal_op(r_op);
                    Done     <= 1'b1;
                    Busy     <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at N=64 and N=8 with hand-computed results.
module tb_multicycle_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    int          checks;
    int          errors;

    logic        start64, start8;
    logic [3:0]  op64, op8;
    logic [63:0] a64, b64, w64;
    logic [7:0]  a8, b8, w8;
    logic        z64, n64, c64, v64, il64, busy64, done64;
    logic        z8, n8, c8, v8, il8, busy8, done8;

    multicycle_alu #(.N(64)) dut64 (
        .Clk(clk), .Reset(rst), .Start(start64), .ALUCtrl(op64),
        .BusA(a64), .BusB(b64), .BusW(w64), .Zero(z64), .Negative(n64),
        .Carry(c64), .Overflow(v64), .Illegal(il64), .Busy(busy64), .Done(done64)
    );

    multicycle_alu #(.N(8)) dut8 (
        .Clk(clk), .Reset(rst), .Start(start8), .ALUCtrl(op8),
        .BusA(a8), .BusB(b8), .BusW(w8), .Zero(z8), .Negative(n8),
        .Carry(c8), .Overflow(v8), .Illegal(il8), .Busy(busy8), .Done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept one op, then count edges until Done is seen (capped at 200).
    task automatic do_op64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                           output int lat);
        @(negedge clk);
        start64 = 1'b1; op64 = op; a64 = a; b64 = b;
        @(posedge clk); #1;
        start64 = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (done64) break;
        end
    endtask

    task automatic do_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat);
        @(negedge clk);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (done8) break;
        end
    endtask

    task automatic test_reset();
        int lat;
        logic saw_done;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (w64 !== 64'h0) begin errors++; $display("FAIL reset_busw got %h expected 0", w64); end
        checks++; if ({z64, n64, c64, v64, il64, busy64, done64} !== 7'b1000000) begin
            errors++; $display("FAIL reset_flags got %b expected 1000000", {z64, n64, c64, v64, il64, busy64, done64}); end
        @(negedge clk); rst = 1'b0;
        // Prime BusW with a nonzero value so the reset clear is observable.
        do_op64(ALU_PASSB, 64'h0, 64'h55, lat);
        @(negedge clk);
        start64 = 1'b1; op64 = ALU_MUL; a64 = 64'd9; b64 = 64'd9;
        @(posedge clk); #1;
        start64 = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (done64) saw_done = 1'b1;
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        if (done64) saw_done = 1'b1;
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midmul_reset_done got 1 expected 0"); end
        checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL midmul_reset_busy got %b expected 0", busy64); end
        checks++; if (w64 !== 64'h0 || z64 !== 1'b1) begin
            errors++; $display("FAIL midmul_reset_out got %h z=%b expected 0 z=1", w64, z64); end
        @(negedge clk); rst = 1'b0;
        do_op64(ALU_ADD, 64'd1, 64'd1, lat);
        checks++; if (lat !== 1 || w64 !== 64'd2) begin
            errors++; $display("FAIL post_reset_add got lat=%0d w=%h expected lat=1 w=2", lat, w64); end
    endtask

    task automatic test_add_sub();
        int lat;
        do_op64(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat);
        checks++; if ({w64, z64, n64, c64, v64} !== {64'h0, 4'b1010}) begin
            errors++; $display("FAIL add_carry got %h zncv=%b%b%b%b expected 0 zncv=1010", w64, z64, n64, c64, v64); end
        do_op64(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, lat);
        checks++; if ({w64, z64, n64, c64, v64} !== {64'h8000_0000_0000_0000, 4'b0101}) begin
            errors++; $display("FAIL add_ovf got %h zncv=%b%b%b%b expected 8000000000000000 zncv=0101", w64, z64, n64, c64, v64); end
        do_op64(ALU_SUB, 64'd5, 64'd7, lat);
        checks++; if ({w64, z64, n64, c64, v64} !== {64'hFFFF_FFFF_FFFF_FFFE, 4'b0100}) begin
            errors++; $display("FAIL sub_borrow got %h zncv=%b%b%b%b expected fffffffffffffffe zncv=0100", w64, z64, n64, c64, v64); end
        do_op64(ALU_SUB, 64'd7, 64'd5, lat);
        checks++; if ({w64, z64, n64, c64, v64} !== {64'd2, 4'b0010}) begin
            errors++; $display("FAIL sub_noborrow got %h zncv=%b%b%b%b expected 2 zncv=0010", w64, z64, n64, c64, v64); end
        do_op64(ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, lat);
        checks++; if ({w64, c64, v64} !== {64'h7FFF_FFFF_FFFF_FFFF, 2'b11}) begin
            errors++; $display("FAIL sub_ovf got %h cv=%b%b expected 7fffffffffffffff cv=11", w64, c64, v64); end
    endtask

    task automatic test_logic_shift();
        int lat;
        do_op64(ALU_AND, 64'hF0, 64'h3C, lat);
        checks++; if (w64 !== 64'h30 || c64 !== 1'b0 || lat !== 1) begin
            errors++; $display("FAIL and got %h c=%b lat=%0d expected 30 c=0 lat=1", w64, c64, lat); end
        do_op64(ALU_OR, 64'hF0, 64'h3C, lat);
        checks++; if (w64 !== 64'hFC) begin errors++; $display("FAIL or got %h expected fc", w64); end
        do_op64(ALU_LSL, 64'd1, 64'h41, lat);
        checks++; if (w64 !== 64'd2) begin errors++; $display("FAIL lsl_mod got %h expected 2", w64); end
        do_op64(ALU_LSR, 64'h8000_0000_0000_0000, 64'd63, lat);
        checks++; if (w64 !== 64'd1) begin errors++; $display("FAIL lsr63 got %h expected 1", w64); end
        do_op64(ALU_LSL, 64'h1234, 64'h40, lat);
        checks++; if (w64 !== 64'h1234) begin errors++; $display("FAIL shift0 got %h expected 1234", w64); end
        do_op64(ALU_PASSB, 64'h99, 64'h0, lat);
        checks++; if (w64 !== 64'h0 || z64 !== 1'b1) begin
            errors++; $display("FAIL passb0 got %h z=%b expected 0 z=1", w64, z64); end
    endtask

    task automatic test_illegal();
        int lat;
        do_op64(4'b1111, 64'd5, 64'd5, lat);
        checks++; if ({lat, w64, z64, il64} !== {32'd1, 64'h0, 2'b11}) begin
            errors++; $display("FAIL illegal got lat=%0d w=%h z=%b il=%b expected lat=1 w=0 z=1 il=1", lat, w64, z64, il64); end
        do_op64(ALU_AND, 64'hFF, 64'h0F, lat);
        checks++; if (il64 !== 1'b0 || w64 !== 64'h0F) begin
            errors++; $display("FAIL illegal_clear got il=%b w=%h expected il=0 w=f", il64, w64); end
    endtask

    task automatic test_mul();
        int lat;
        logic held;
        logic seen;
        do_op64(ALU_PASSB, 64'h0, 64'hABCD, lat);
        @(negedge clk);
        start64 = 1'b1; op64 = ALU_MUL; a64 = 64'h1_0000_0001; b64 = 64'd3;
        @(posedge clk); #1;
        start64 = 1'b0;
        lat = 0; held = 1'b1; seen = 1'b0;
        while (lat < 200 && !seen) begin
            if (lat == 5) begin
                @(negedge clk); start64 = 1'b1; op64 = ALU_ADD; a64 = 64'd1; b64 = 64'd1;
            end else if (lat == 6) begin
                @(negedge clk); start64 = 1'b0; a64 = '1; b64 = '1;
            end
            @(posedge clk); #1;
            lat++;
            if (done64) seen = 1'b1;
            else if (w64 !== 64'hABCD) held = 1'b0;
        end
        checks++; if (lat !== 65) begin errors++; $display("FAIL mul_latency got %0d expected 65", lat); end
        checks++; if (w64 !== 64'h3_0000_0003) begin errors++; $display("FAIL mul_result got %h expected 300000003", w64); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL mul_busw_held got 0 expected 1"); end
        @(posedge clk); #1;
        checks++; if (busy64 !== 1'b0 || done64 !== 1'b0) begin
            errors++; $display("FAIL mul_start_not_queued got busy=%b done=%b expected 0 0", busy64, done64); end
    endtask

    task automatic test_back_to_back();
        int dones;
        @(negedge clk);
        start64 = 1'b1; op64 = ALU_ADD; a64 = 64'd3; b64 = 64'd4;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done64) dones++;
        end
        @(negedge clk); start64 = 1'b0;
        checks++; if (dones !== 3 || w64 !== 64'd7) begin
            errors++; $display("FAIL back_to_back got dones=%0d w=%h expected 3 w=7", dones, w64); end
    endtask

    task automatic test_n8();
        int lat;
        do_op8(ALU_MUL, 8'h10, 8'h10, lat);
        checks++; if ({lat, w8, z8} !== {32'd9, 8'h00, 1'b1}) begin
            errors++; $display("FAIL n8_mul got lat=%0d w=%h z=%b expected lat=9 w=0 z=1", lat, w8, z8); end
        do_op8(ALU_MUL, 8'h0D, 8'h0B, lat);
        checks++; if (w8 !== 8'h8F) begin errors++; $display("FAIL n8_mul2 got %h expected 8f", w8); end
        do_op8(ALU_ADD, 8'hFF, 8'h01, lat);
        checks++; if ({w8, z8, n8, c8, v8} !== {8'h00, 4'b1010}) begin
            errors++; $display("FAIL n8_add_carry got %h zncv=%b%b%b%b expected 0 zncv=1010", w8, z8, n8, c8, v8); end
        do_op8(ALU_ADD, 8'h7F, 8'h01, lat);
        checks++; if ({w8, z8, n8, c8, v8} !== {8'h80, 4'b0101}) begin
            errors++; $display("FAIL n8_add_ovf got %h zncv=%b%b%b%b expected 80 zncv=0101", w8, z8, n8, c8, v8); end
    endtask

    initial begin
        checks = 0; errors = 0;
        start64 = 1'b0; op64 = 4'b0000; a64 = '0; b64 = '0;
        start8 = 1'b0; op8 = 4'b0000; a8 = '0; b8 = '0;
        rst = 1'b1;
        test_reset();
        test_add_sub();
        test_logic_shift();
        test_illegal();
        test_mul();
        test_back_to_back();
        test_n8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, clocked successor to the datapath's combinational ALU.
- Keeps the existing ALUCtrl opcode encodings and fixes AND/OR to be bitwise.
- Adds logical shifts, an iterative unsigned multiply, registered NZCV flags and a Start/Busy/Done handshake.
- Sits in the execute stage of the multi-cycle datapath. The control FSM holds operands and waits on Done.

Parameters:
- N, 64, operand/result width in bits (N ≥ 8, power of two).
- SHW, $clog2(N), shift-amount width taken from BusB[SHW-1:0].
- CW, $clog2(N+1), multiply iteration counter width.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; accepted only when Busy=0.
- ALUCtrl  in  4  opcode, sampled on accept.
- BusA  in  N  operand A, sampled on accept.
- BusB  in  N  operand B, sampled on accept.
- BusW  out  N  registered result, held until the next Done.
- Zero  out  1  registered, BusW==0.
- Negative  out  1  registered, BusW[N-1].
- Carry  out  1  registered carry-out (ADD) / no-borrow (SUB), else 0.
- Overflow  out  1  registered signed overflow (ADD/SUB), else 0.
- Illegal  out  1  registered, last accepted opcode was unsupported.
- Busy  out  1  high while an accepted op is in progress.
- Done  out  1  one-cycle pulse; outputs updated in this same cycle.

Behaviour:
- Reset (synchronous, wins over everything, including mid-MUL): state=IDLE; BusW=0, Zero=1, Negative=0, Carry=0, Overflow=0, Illegal=0, Busy=0, Done=0; counter and partial product cleared; the in-flight op is discarded with no Done.
- Opcodes:
  - 0000 AND, A&B.
  - 0001 OR, A|B.
  - 0010 ADD, A+B.
  - 0011 LSL, A << B[SHW-1:0].
  - 0100 LSR, A >> B[SHW-1:0] (zero fill).
  - 0101 MUL, low N bits of unsigned A*B.
  - 0110 SUB, A-B.
  - 0111 PassB, B.
  - Any other code: Illegal=1, BusW=0, flags from BusW (Zero=1, Negative=0, Carry=0, Overflow=0).
- State IDLE:
  - If Start: latch ALUCtrl/BusA/BusB.
  - Non-MUL: go to DONE.
  - MUL: clear accumulator, load counter=N, go to MUL.
  - Busy=1 in every state except IDLE.
- State MUL:
  - Each cycle: if multiplier LSB=1, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter -= 1.
  - When counter reaches 0, go to DONE.
  - Exactly N cycles in MUL; no early termination on a zero multiplier (latency is deterministic).
- State DONE (one cycle): BusW and flags load; Done=1 and Busy=0 during this cycle; next state IDLE.
- Latency (accept edge → Done high): 1 cycle for non-MUL ops; N+1 cycles for MUL.
- Throughput: a new Start is accepted in the first cycle Busy is 0 after DONE, i.e. back-to-back non-MUL ops every 2 cycles.
- Start while Busy=1 is ignored entirely (not queued). Operand changes after accept have no effect.
- Arithmetic:
  - ADD/SUB computed at N+1 bits; Carry = bit N.
  - SUB = A + ~B + 1, so Carry=1 iff A ≥ B unsigned.
  - Overflow = (A[N-1]==B'[N-1]) && (R[N-1]!=A[N-1]), with B' = B for ADD and ~B for SUB.
- Wrap-around: ADD/SUB/MUL results are modulo 2^N. Shift amount is taken modulo N via the B[SHW-1:0] truncation; shift by 0 returns A.
- Outputs BusW/flags/Illegal change only in DONE or on Reset.

Decomposition:
- Shared package `alu_pkg`:
  - 4-bit opcode localparams `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_LSL`, `ALU_LSR`, `ALU_MUL`, `ALU_SUB`, `ALU_PASSB`.
  - State encoding IDLE/MUL/DONE.
  - Reused by the control unit, replacing the scattered `define`s.
- One natural sub-module `alu_shift_add_mul` (N-parameterised): start/done; holds counter, accumulator, multiplicand and multiplier registers. The top keeps the FSM, the single-cycle datapath and the flag logic.

Test Plan:
- Reset asserted mid-MUL (cycle 10 of 64) → no Done pulse; next cycle Busy=0, BusW=0, Zero=1; a subsequent ADD 1+1 gives Done after 1 cycle with BusW=2.
- ADD A=0xFFFF_FFFF_FFFF_FFFF, B=1 → BusW=0, Zero=1, Carry=1, Overflow=0. ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1 → BusW=0x8000_0000_0000_0000, Negative=1, Overflow=1, Carry=0.
- SUB A=5, B=7 → BusW=0xFFFF_FFFF_FFFF_FFFE, Negative=1, Carry=0. SUB 7,5 → BusW=2, Carry=1.
- MUL A=0x1_0000_0001, B=3 → Done exactly 65 cycles after accept; BusW=0x3_0000_0003. Start pulses and operand changes during Busy are ignored and BusW is unchanged.
- AND 0xF0,0x3C → 0x30; OR → 0xFC; LSL 1 by B=0x41 → 2 (amount mod 64); LSR 0x8000_0000_0000_0000 by 63 → 1; PassB 0 → Zero=1.
- Opcode 1111 → Illegal=1, BusW=0, Done after 1 cycle; following valid op clears Illegal. Repeat MUL and ADD checks with N=8: MUL 0x10*0x10 → 0x00, Zero=1, Done at 9 cycles.
